// File: rtl/csa_frame_builder.sv
// Buffers complete 47-word TS packets and replays each one as a 55-word frame
// (8-word descriptor, then the payload) for the CSA scrambler input port.
module csa_frame_builder #(
  parameter int FIFO_AW = 7
) (
  input  logic         clk_main,
  input  logic         rst,
  input  logic [31:0]  ts_in,
  input  logic         ts_in_en,
  input  logic         ts_in_sop,
  output logic         ts_in_rdy,
  input  logic [63:0]  cw_even,
  input  logic [63:0]  cw_odd,
  input  logic [127:0] aux_in,
  output logic [32:0]  ts_out_csa,
  output logic         ts_out_csa_en,
  output logic [15:0]  drop_cnt
);
  localparam int            PW      = FIFO_AW + 1;
  localparam int            DEPTH   = 1 << FIFO_AW;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] FULL    = PW'(DEPTH);
  localparam logic [PW-1:0] RDY_MAX = PW'(DEPTH - 3);

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_data_q;
  logic [PW-1:0] wptr_spec_q, wptr_com_q, rptr_q, pkt_cnt_q;
  logic [5:0]    wcnt_q, pcnt_q;
  logic [2:0]    hcnt_q;
  logic          sync_ok_q, err_q, commit_q, rdy_q;
  logic [15:0]   drop_q;
  state_t        state_q;
  logic [63:0]   cw_q;
  logic [127:0]  aux_q;
  logic          bypass_q, odd_q;
  logic [32:0]   out_q;
  logic          out_en_q;

  logic          sop_restart, accept, buf_full, wr_en, last_word, pkt_good;
  logic          drop_inc, pkt_dec, odd_sel, byp_sel;
  logic [PW-1:0] base_ptr_d, occ_d, pkt_cnt_d;
  logic [32:0]   hdr_word_d;
  logic [31:0]   aux_w [4];

  // A restarting SOP overwrites the abandoned partial from the committed pointer.
  assign sop_restart = ts_in_en & ts_in_sop & (wcnt_q != 6'd0);
  assign accept      = ts_in_en & (ts_in_sop | (wcnt_q != 6'd0));
  assign base_ptr_d  = sop_restart ? wptr_com_q : wptr_spec_q;
  assign occ_d       = base_ptr_d - rptr_q;
  assign buf_full    = (occ_d == FULL);
  assign wr_en       = accept & ~buf_full;
  assign last_word   = accept & ~ts_in_sop & (wcnt_q == 6'd46);
  assign pkt_good    = sync_ok_q & ~err_q & ~buf_full;
  assign drop_inc    = sop_restart | (last_word & ~pkt_good);
  assign pkt_dec     = (state_q == PAY) && (pcnt_q == 6'd46);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({commit_q, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (rst && wr_en) mem_q[base_ptr_d[FIFO_AW-1:0]] <= ts_in;
    rd_data_q <= mem_q[rptr_q[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk_main) begin
    if (!rst) begin
      wptr_spec_q <= '0;
      wptr_com_q  <= '0;
      wcnt_q      <= '0;
      sync_ok_q   <= 1'b0;
      err_q       <= 1'b0;
      commit_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_q      <= '0;
      rdy_q       <= 1'b0;
    end else begin
      commit_q  <= 1'b0;
      pkt_cnt_q <= pkt_cnt_d;
      rdy_q     <= ((wptr_spec_q - rptr_q) <= RDY_MAX);
      if (commit_q) wptr_com_q <= wptr_spec_q;
      if (accept) begin
        if (ts_in_sop) begin
          wcnt_q    <= 6'd1;
          sync_ok_q <= (ts_in[31:24] == 8'h47);
          err_q     <= buf_full;
        end else if (last_word) begin
          wcnt_q <= 6'd0;
        end else begin
          wcnt_q <= wcnt_q + 6'd1;
          if (buf_full) err_q <= 1'b1;
        end
        if (last_word && !pkt_good) wptr_spec_q <= wptr_com_q;
        else if (wr_en)             wptr_spec_q <= base_ptr_d + PTR_ONE;
        else if (sop_restart)       wptr_spec_q <= wptr_com_q;
        if (last_word && pkt_good) commit_q <= 1'b1;
      end
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_aux
    assign aux_w[gi] = aux_q[127 - 32*gi -: 32];
  end

  // tsc 00/01 means clear packet: bypass with the even word in w2/w3.
  assign odd_sel = (rd_data_q[7:6] == 2'b11);
  assign byp_sel = ~rd_data_q[7];

  always_comb begin
    hdr_word_d = 33'd0;
    case (hcnt_q)
      3'd1:    hdr_word_d = {1'b0, 30'b0, bypass_q, odd_q};
      3'd2:    hdr_word_d = {1'b0, cw_q[63:32]};
      3'd3:    hdr_word_d = {1'b0, cw_q[31:0]};
      3'd4:    hdr_word_d = {1'b0, aux_w[0]};
      3'd5:    hdr_word_d = {1'b0, aux_w[1]};
      3'd6:    hdr_word_d = {1'b0, aux_w[2]};
      3'd7:    hdr_word_d = {1'b0, aux_w[3]};
      default: hdr_word_d = 33'd0;
    endcase
  end

  // rptr runs one word ahead of the output so the registered read lines up with PAY.
  always_ff @(posedge clk_main) begin
    if (!rst) begin
      state_q  <= IDLE;
      rptr_q   <= '0;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      cw_q     <= '0;
      aux_q    <= '0;
      bypass_q <= 1'b0;
      odd_q    <= 1'b0;
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_en_q <= 1'b0;
          if (pkt_cnt_q != '0) begin
            cw_q     <= odd_sel ? cw_odd : cw_even;
            aux_q    <= aux_in;
            bypass_q <= byp_sel;
            odd_q    <= odd_sel;
            out_q    <= {1'b1, 32'h0000_0001};
            out_en_q <= 1'b1;
            hcnt_q   <= 3'd1;
            state_q  <= HDR;
          end
        end
        HDR: begin
          out_q  <= hdr_word_d;
          hcnt_q <= hcnt_q + 3'd1;
          if (hcnt_q == 3'd7) begin
            state_q <= PAY;
            pcnt_q  <= 6'd0;
            rptr_q  <= rptr_q + PTR_ONE;
          end
        end
        PAY: begin
          out_q <= {1'b0, rd_data_q};
          if (pcnt_q == 6'd46) begin
            state_q <= GAP;
          end else begin
            pcnt_q <= pcnt_q + 6'd1;
            rptr_q <= rptr_q + PTR_ONE;
          end
        end
        default: begin
          out_q    <= '0;
          out_en_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ts_in_rdy     = rdy_q;
  assign ts_out_csa    = out_q;
  assign ts_out_csa_en = out_en_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_csa_frame_builder.sv
// Scoreboard bench for csa_frame_builder: stimulus queues expected frame words,
// a monitor pops and compares every word the DUT emits.
module tb_csa_frame_builder;
  logic         clk_main = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  ts_in = '0;
  logic         ts_in_en = 1'b0;
  logic         ts_in_sop = 1'b0;
  logic         ts_in_rdy;
  logic [63:0]  cw_even = 64'h1111_2222_3333_4444;
  logic [63:0]  cw_odd  = 64'hAAAA_BBBB_CCCC_DDDD;
  logic [127:0] aux_in  = {32'h10, 32'h1, 32'hC012_0801, 32'h4E20};
  logic [32:0]  ts_out_csa;
  logic         ts_out_csa_en;
  logic [15:0]  drop_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q [$];
  int          mon_pos = 0;
  int          idle_run = 0;
  int          frames_seen = 0;
  int          b2b_frames = 0;
  bit          gap_chk = 1'b0;
  bit          rdy_low_seen = 1'b0;

  csa_frame_builder #(.FIFO_AW(7)) dut (
    .clk_main(clk_main), .rst(rst), .ts_in(ts_in), .ts_in_en(ts_in_en),
    .ts_in_sop(ts_in_sop), .ts_in_rdy(ts_in_rdy), .cw_even(cw_even),
    .cw_odd(cw_odd), .aux_in(aux_in), .ts_out_csa(ts_out_csa),
    .ts_out_csa_en(ts_out_csa_en), .drop_cnt(drop_cnt)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s bound expired", name);
  endtask

  function automatic logic [31:0] pkt_word(input logic [31:0] head, input logic [7:0] seed, input int k);
    logic [7:0] b;
    if (k == 0) return head;
    b = seed + 8'(4*k - 3);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic push_frame(input logic [31:0] head, input logic [7:0] seed,
                            input logic [31:0] w1, input logic [63:0] cw);
    exp_q.push_back({1'b1, 32'h0000_0001});
    exp_q.push_back({1'b0, w1});
    exp_q.push_back({1'b0, cw[63:32]});
    exp_q.push_back({1'b0, cw[31:0]});
    exp_q.push_back({1'b0, aux_in[127:96]});
    exp_q.push_back({1'b0, aux_in[95:64]});
    exp_q.push_back({1'b0, aux_in[63:32]});
    exp_q.push_back({1'b0, aux_in[31:0]});
    for (int k = 0; k < 47; k++) exp_q.push_back({1'b0, pkt_word(head, seed, k)});
  endtask

  task automatic drive(input logic [31:0] w, input logic sop);
    int t;
    t = 0;
    while (ts_in_rdy !== 1'b1 && t < 2000) begin
      rdy_low_seen = 1'b1;
      ts_in_en = 1'b0;
      @(negedge clk_main);
      t++;
    end
    if (t >= 2000) fail_now("rdy_wait");
    ts_in = w;
    ts_in_sop = sop;
    ts_in_en = 1'b1;
    @(negedge clk_main);
    ts_in_en = 1'b0;
    ts_in_sop = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] head, input logic [7:0] seed, input int n);
    for (int k = 0; k < n; k++) drive(pkt_word(head, seed, k), k == 0);
    $display("sent head=%h seed=%h words=%0d drop_cnt=%0d", head, seed, n, drop_cnt);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_pos != 0) && t < 5000) begin
      @(negedge clk_main);
      t++;
    end
    repeat (4) @(negedge clk_main);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk_main) begin
    logic [32:0] e;
    #1;
    if (!rst) begin
      chk("reset_out_en", {31'd0, ts_out_csa_en, ts_out_csa}, 64'd0);
      exp_q.delete();
      mon_pos = 0;
      idle_run = 0;
    end else if (ts_out_csa_en) begin
      if (ts_out_csa[32] && gap_chk) begin
        if (b2b_frames > 0) chk("frame_gap", 64'(idle_run), 64'd1);
        b2b_frames++;
      end
      idle_run = 0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", ts_out_csa);
      end else begin
        e = exp_q.pop_front();
        chk("frame_word", 64'(ts_out_csa), 64'(e));
      end
      if (mon_pos == 54) begin
        mon_pos = 0;
        frames_seen++;
        $display("frame %0d complete", frames_seen);
      end else begin
        mon_pos++;
      end
    end else begin
      if (mon_pos != 0) begin
        checks++;
        failures++;
        $display("FAIL frame_bubble actual=pos%0d required=pos0", mon_pos);
      end
      mon_pos = 0;
      idle_run++;
    end
  end

  logic [31:0] b2b_w1 [4] = '{32'h2, 32'h2, 32'h0, 32'h1};

  initial begin
    int t;
    repeat (3) @(negedge clk_main);
    chk("reset_rdy", 64'(ts_in_rdy), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk_main);
    chk("rdy_rise", 64'(ts_in_rdy), 64'd1);

    // Single clear packet, with exact start latency and late CW/aux changes.
    push_frame(32'h4740_0100, 8'h00, 32'h2, 64'h1111_2222_3333_4444);
    send_words(32'h4740_0100, 8'h00, 47);
    @(posedge clk_main); #1;
    chk("lat_commit_edge", 64'(ts_out_csa_en), 64'd0);
    @(posedge clk_main); #1;
    chk("lat_first_word", {31'd0, ts_out_csa_en, ts_out_csa}, {31'd0, 1'b1, 33'h1_0000_0001});
    cw_even = 64'hDEAD_BEEF_DEAD_BEEF;
    aux_in  = {4{32'h5555_AAAA}};
    @(negedge clk_main);
    wait_drain();
    cw_even = 64'h1111_2222_3333_4444;
    aux_in  = {32'h10, 32'h1, 32'hC012_0801, 32'h4E20};

    // Scrambling-control selection.
    push_frame(32'h4740_00C0, 8'h20, 32'h1, 64'hAAAA_BBBB_CCCC_DDDD);
    send_words(32'h4740_00C0, 8'h20, 47);
    push_frame(32'h4740_0080, 8'h40, 32'h0, 64'h1111_2222_3333_4444);
    send_words(32'h4740_0080, 8'h40, 47);
    push_frame(32'h4740_0040, 8'h60, 32'h2, 64'h1111_2222_3333_4444);
    send_words(32'h4740_0040, 8'h60, 47);
    wait_drain();
    chk("drop_none", 64'(drop_cnt), 64'd0);

    // Truncated packet followed by a good one, then a bad sync byte.
    send_words(32'h4740_0080, 8'h80, 20);
    push_frame(32'h4740_00C0, 8'h90, 32'h1, 64'hAAAA_BBBB_CCCC_DDDD);
    send_words(32'h4740_00C0, 8'h90, 47);
    chk("drop_partial", 64'(drop_cnt), 64'd1);
    send_words(32'h4640_0080, 8'hA0, 47);
    @(negedge clk_main);
    chk("drop_badsync", 64'(drop_cnt), 64'd2);
    wait_drain();

    // Back-to-back packets until the buffer fills and backpressure appears.
    rdy_low_seen = 1'b0;
    gap_chk = 1'b1;
    for (int p = 0; p < 14; p++) begin
      push_frame(32'h4740_0000 | (32'(p % 4) << 6), 8'(p * 8 + 3), b2b_w1[p % 4],
                 (p % 4 == 3) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'h1111_2222_3333_4444);
      send_words(32'h4740_0000 | (32'(p % 4) << 6), 8'(p * 8 + 3), 47);
    end
    wait_drain();
    gap_chk = 1'b0;
    chk("b2b_rdy_dropped", 64'(rdy_low_seen), 64'd1);
    chk("b2b_frames", 64'(b2b_frames), 64'd14);
    chk("b2b_drop", 64'(drop_cnt), 64'd2);

    // Reset while descriptor word 5 is on the output.
    push_frame(32'h4740_0080, 8'h11, 32'h0, 64'h1111_2222_3333_4444);
    send_words(32'h4740_0080, 8'h11, 47);
    t = 0;
    while (mon_pos != 6 && t < 500) begin
      @(negedge clk_main);
      t++;
    end
    if (t >= 500) fail_now("wait_hdr5");
    rst = 1'b0;
    repeat (3) @(negedge clk_main);
    chk("midrst_rdy", 64'(ts_in_rdy), 64'd0);
    rst = 1'b1;
    @(negedge clk_main);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    chk("midrst_rdy_rise", 64'(ts_in_rdy), 64'd1);
    repeat (80) @(negedge clk_main);
    push_frame(32'h4740_00C0, 8'h33, 32'h1, 64'hAAAA_BBBB_CCCC_DDDD);
    send_words(32'h4740_00C0, 8'h33, 47);
    wait_drain();

    // Saturation: a continuous run of SOP words discards a partial every cycle.
    for (int i = 0; i < 65540; i++) begin
      drive(32'h1234_5600, 1'b1);
      if (i == 99) chk("sat_mid", 64'(drop_cnt), 64'd99);
    end
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
    send_words(32'h4640_0000, 8'h55, 47);
    @(negedge clk_main);
    chk("sat_after_bad", 64'(drop_cnt), 64'hFFFF);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
